// File: rtl/larpix_config_responder.sv
// Chip-side configuration responder: pulls 64-bit packets from the UART
// receiver, filters on parity/declare/magic/chip ID, executes register map
// writes and reads, and loads one reply per accepted command into the
// UART transmitter.
module larpix_config_responder #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned REGNUM    = 256,
  parameter logic [7:0]  GLOBAL_ID = 8'd255,
  parameter logic [31:0] MAGIC     = 32'h8950_4E47
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       chip_id,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_empty,
  output logic             uld_rx_data,
  output logic [WIDTH-1:0] tx_data,
  output logic             ld_tx_data,
  input  logic             tx_busy,
  input  logic [7:0]       dbg_addr,
  output logic [7:0]       dbg_data,
  output logic [7:0]       rx_pkt_cnt,
  output logic [7:0]       bad_pkt_cnt,
  output logic [7:0]       parity_err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNLOAD,
    S_DECODE,
    S_EXEC,
    S_REPLY
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pkt_q;
  logic [WIDTH-1:0] tx_data_q;
  logic [7:0]       regmap_q [REGNUM];
  logic [7:0]       rx_cnt_q, bad_cnt_q, par_cnt_q;

  logic inc_rx, inc_bad, inc_par;

  // Packet field decode of the captured command
  logic [1:0]       pkt_decl;
  logic [7:0]       pkt_chip, pkt_addr, pkt_data;
  logic [31:0]      pkt_magic;
  logic             par_ok, decl_ok, magic_ok, id_ok, is_write;
  logic [7:0]       exec_data;
  logic [WIDTH-2:0] reply_body;
  logic [WIDTH-1:0] reply_word;

  assign pkt_decl  = pkt_q[1:0];
  assign pkt_chip  = pkt_q[9:2];
  assign pkt_addr  = pkt_q[17:10];
  assign pkt_data  = pkt_q[25:18];
  assign pkt_magic = pkt_q[57:26];

  assign par_ok    = (pkt_q[WIDTH-1] == ~^pkt_q[WIDTH-2:0]);
  assign decl_ok   = pkt_decl[1];
  assign magic_ok  = (pkt_magic == MAGIC);
  assign id_ok     = (pkt_chip == chip_id) || (pkt_chip == GLOBAL_ID);
  assign is_write  = (pkt_decl == 2'd2);

  // Reply data: written value for writes, pre-write map contents for reads
  assign exec_data  = is_write ? pkt_data : regmap_q[pkt_addr];
  assign reply_body = {1'b1, 4'b0000, MAGIC, exec_data, pkt_addr, chip_id, pkt_decl};
  assign reply_word = {~^reply_body, reply_body};

  assign tx_data        = tx_data_q;
  assign dbg_data       = regmap_q[dbg_addr];
  assign rx_pkt_cnt     = rx_cnt_q;
  assign bad_pkt_cnt    = bad_cnt_q;
  assign parity_err_cnt = par_cnt_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state, strobes and counter increment requests
  always_comb begin
    state_d     = state_q;
    uld_rx_data = 1'b0;
    ld_tx_data  = 1'b0;
    inc_rx      = 1'b0;
    inc_bad     = 1'b0;
    inc_par     = 1'b0;
    case (state_q)
      S_IDLE:   if (!rx_empty) state_d = S_UNLOAD;
      S_UNLOAD: begin
        uld_rx_data = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_IDLE;
        if (!par_ok) begin
          inc_par = 1'b1;
          inc_bad = 1'b1;
        end else if (!decl_ok || !magic_ok) begin
          inc_bad = 1'b1;
        end else if (id_ok) begin
          inc_rx  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC:   state_d = S_REPLY;
      S_REPLY:  if (!tx_busy) begin
        ld_tx_data = 1'b1;
        state_d    = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Packet capture during the unload strobe, reply build in EXEC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_q     <= '0;
      tx_data_q <= '0;
    end else begin
      if (state_q == S_UNLOAD) pkt_q     <= rx_data;
      if (state_q == S_EXEC)   tx_data_q <= reply_word;
    end
  end

  // Register map, written in EXEC for write commands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < REGNUM; i++) regmap_q[i] <= '0;
    end else if (state_q == S_EXEC && is_write) begin
      regmap_q[pkt_addr] <= pkt_data;
    end
  end

  // Saturating status counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_cnt_q  <= '0;
      bad_cnt_q <= '0;
      par_cnt_q <= '0;
    end else begin
      if (inc_rx  && rx_cnt_q  != '1) rx_cnt_q  <= rx_cnt_q  + 8'd1;
      if (inc_bad && bad_cnt_q != '1) bad_cnt_q <= bad_cnt_q + 8'd1;
      if (inc_par && par_cnt_q != '1) par_cnt_q <= par_cnt_q + 8'd1;
    end
  end

endmodule

// File: doc/larpix_config_responder.md
# larpix_config_responder

Chip-side responder for the 64-bit configuration packet protocol driven by the FPGA master. It pulls packets from the chip's UART receiver and validates parity, declaration, magic number and chip ID. It executes configuration writes and reads against an internal 256 x 8 register map, then hands one reply packet per accepted command to the chip's UART transmitter. It sits between `uart_rx` (fed by posi) and `uart_tx` (driving piso).

## Interface
- WIDTH, 64: packet width.
- REGNUM, 256: number of 8-bit registers.
- GLOBAL_ID, 255: broadcast chip ID.
- MAGIC, 32'h8950_4E47: required magic number, bits [57:26].
- clk input 1: system clock. Single clock domain.
- reset_n input 1: asynchronous, active-low reset.
- chip_id input 8: this chip's ID. Static during operation.
- rx_data input 64: word from the UART receiver. Valid while rx_empty=0.
- rx_empty input 1: low when the receiver holds an unread word.
- uld_rx_data output 1: one-cycle unload strobe to the receiver.
- tx_data output 64: reply word to the UART transmitter.
- ld_tx_data output 1: one-cycle load strobe to the transmitter.
- tx_busy input 1: transmitter busy. Loading is forbidden while high.
- dbg_addr input 8: register map probe address.
- dbg_data output 8: regmap[dbg_addr]. Combinational read.
- rx_pkt_cnt output 8: accepted command count. Saturates at 255.
- bad_pkt_cnt output 8: discarded packet count, any reason. Saturates at 255.
- parity_err_cnt output 8: parity failure count. Saturates at 255.

## Operation
- Packet fields:
  - [1:0] declare: 2 = write, 3 = read; 0 and 1 are invalid here.
  - [9:2] chip ID.
  - [17:10] register address.
  - [25:18] register data.
  - [57:26] magic number.
  - [61:58] FIFO flags.
  - [62] downstream marker.
  - [63] parity.
- Parity is odd: a packet is good when bit63 == ~^bits[62:0].
- FSM states are IDLE, UNLOAD, DECODE, EXEC, REPLY.
  - IDLE -> UNLOAD when rx_empty=0.
  - UNLOAD: assert uld_rx_data for one cycle; capture rx_data into pkt_q the same cycle; go to DECODE.
  - DECODE checks, in priority order:
    - Parity fails: parity_err_cnt++, bad_pkt_cnt++, go to IDLE.
    - Declare is not 2 or 3: bad_pkt_cnt++, go to IDLE.
    - Magic != MAGIC: bad_pkt_cnt++, go to IDLE.
    - Chip ID != chip_id and != GLOBAL_ID: drop silently (no counter), go to IDLE.
    - Otherwise: rx_pkt_cnt++, go to EXEC.
  - EXEC, write: regmap[addr] <= data. Reply data field = written data.
  - EXEC, read: reply data field = regmap[addr] as of this cycle.
  - EXEC then goes to REPLY.
  - REPLY: wait while tx_busy=1. On the first cycle with tx_busy=0, present tx_data and pulse ld_tx_data, then go to IDLE.
- Reply word:
  - Declare is copied from the command.
  - [9:2] = chip_id. This applies to broadcast commands too.
  - Address is copied.
  - Data is set as in EXEC.
  - Magic = MAGIC.
  - [61:58] = 0.
  - [62] = 1.
  - [63] recomputed for odd parity.
- tx_data holds its value after the load until the next reply.
- No new unload occurs until the pending reply is loaded; the receiver buffers further traffic.
- A broadcast write updates this chip's register and produces a reply.
- A write followed by a read of the same address returns the new value.
- Counters saturate at 255 and never wrap.

## Timing
- Reset (asynchronous assert, synchronous release by clk):
  - FSM goes to IDLE.
  - uld_rx_data = 0, ld_tx_data = 0, tx_data = 0.
  - All counters = 0.
  - All regmap entries = 8'h00.
  - A packet in flight is discarded.
  - After reset, IDLE unloads whatever the receiver then presents.
- Let rx_empty fall at cycle N:
  - N+1: uld_rx_data = 1 (UNLOAD).
  - N+2: DECODE.
  - N+3: EXEC; a write is visible on dbg_data from cycle N+4.
  - N+4: REPLY, and ld_tx_data = 1 if tx_busy = 0.
- Minimum command-to-load latency is 4 cycles. Each extra tx_busy cycle adds one.
- A discarded packet returns to IDLE at N+3. A following packet is unloaded no earlier than N+4.
- ld_tx_data and uld_rx_data are never high in the same cycle. Each is exactly one cycle wide.
- If tx_busy rises in the same cycle ld_tx_data would assert, the load is deferred; tx_busy is sampled in that cycle.

## Test plan
- Write to own chip: chip_id = 16, write addr 8'h05 data 8'hA5 with valid magic and parity.
  - Reply has declare = 2, chip = 16, addr = 5, data = A5, marker = 1, odd parity.
  - dbg_data at addr 5 reads A5.
  - rx_pkt_cnt = 1.
- Read after write: read addr 5, then read addr 6 without a prior write.
  - Replies carry data A5 and 00 respectively, with declare = 3.
- Broadcast: write chip = 255, addr 10, data 3C while chip_id = 16.
  - Register is written.
  - Reply has chip field = 16.
- Filters:
  - Bad parity packet: parity_err_cnt = 1, bad_pkt_cnt = 1, no ld_tx_data.
  - Packet with magic 0: bad_pkt_cnt = 2, no ld_tx_data.
  - Packet with chip = 31: all counters unchanged, no ld_tx_data.
  - Declare = 1: bad_pkt_cnt = 3, no ld_tx_data.
- Backpressure: hold tx_busy = 1 for 50 cycles during a read.
  - ld_tx_data pulses in the first cycle after tx_busy falls.
  - A second queued packet is not unloaded before that pulse.
- Reset mid-reply: assert reset_n = 0 in the REPLY state.
  - All outputs and counters read 0 and the regmap is cleared.
  - No ld_tx_data pulse.
  - Saturation: 300 accepted commands leave rx_pkt_cnt = 255.
